// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared state encoding and default sizes for the APB round-robin master
package apb_pkg;

    localparam int APB_ADDR_W  = 32;
    localparam int APB_DATA_W  = 32;
    localparam int APB_NUM_REQ = 4;
    localparam int APB_TIMEOUT = 16;

    // Transfer phases of the APB master.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with last-grant pointer
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   req          eligible requesters (one bit each)
//   grant_en     pointer advances to grant_idx when high
//   grant_idx    index of the winner, valid when grant_valid
//   grant_valid  at least one requester is eligible
module rr_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ = APB_NUM_REQ,
    parameter int IDXW    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               grant_en,
    output logic [IDXW-1:0]    grant_idx,
    output logic               grant_valid
);

    logic [IDXW-1:0] last_grant;
    logic [IDXW-1:0] cand;

    // Search begins one past the previous winner so every requester
    // gets a turn before anyone is served twice.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDXW'((int'(last_grant) + i) % NUM_REQ);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Reset to the last index so requester 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= IDXW'(NUM_REQ - 1);
        end else if (grant_en) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/apb_rr_master.sv
// rtl/apb_rr_master.sv - APB master serving several requesters in round-robin order
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req, req_write           per-requester request level and direction (1 = write)
//   req_addr, req_wdata      packed per-requester address and write data
//   done                     one-hot completion pulse
//   rdata_o, err_o           captured read data and error, held until next completion
//   sel, enable, write       APB control to the slave
//   addr, wdata              APB address and write data to the slave
//   rdata, ready, err        APB response from the slave
module apb_rr_master
    import apb_pkg::*;
#(
    parameter int addrWidth = APB_ADDR_W,
    parameter int dataWidth = APB_DATA_W,
    parameter int NUM_REQ   = APB_NUM_REQ,
    parameter int TIMEOUT   = APB_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           req_write,
    input  logic [NUM_REQ*addrWidth-1:0] req_addr,
    input  logic [NUM_REQ*dataWidth-1:0] req_wdata,
    output logic [NUM_REQ-1:0]           done,
    output logic [dataWidth-1:0]         rdata_o,
    output logic                         err_o,
    output logic                         sel,
    output logic                         enable,
    output logic                         write,
    output logic [addrWidth-1:0]         addr,
    output logic [dataWidth-1:0]         wdata,
    input  logic [dataWidth-1:0]         rdata,
    input  logic                         ready,
    input  logic                         err
);

    localparam int IDXW = $clog2(NUM_REQ);
    localparam int CW   = $clog2(TIMEOUT + 1);

    apb_state_e      state;
    logic [IDXW-1:0] winner;
    logic [CW-1:0]   wait_cnt;
    logic [NUM_REQ-1:0] eligible;
    logic [IDXW-1:0] grant_idx;
    logic            grant_valid;
    logic            grant_en;

    // A requester that is receiving its done pulse this cycle is not
    // eligible, which keeps it from being re-granted on a stale level.
    assign eligible = req & ~done;
    assign grant_en = (state == IDLE) && grant_valid;

    assign sel    = (state != IDLE);
    assign enable = (state == ACCESS);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDXW)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (eligible),
        .grant_en    (grant_en),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            winner   <= '0;
            write    <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
            done     <= '0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        winner <= grant_idx;
                        write  <= req_write[grant_idx];
                        addr   <= req_addr[grant_idx*addrWidth +: addrWidth];
                        wdata  <= req_wdata[grant_idx*dataWidth +: dataWidth];
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (ready) begin
                        rdata_o      <= write ? '0 : rdata;
                        err_o        <= err;
                        done[winner] <= 1'b1;
                        state        <= IDLE;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        // Slave never answered: report a timeout as an error.
                        rdata_o      <= '0;
                        err_o        <= 1'b1;
                        done[winner] <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rr_master.sv
// tb/tb_apb_rr_master.sv - self-checking bench for apb_rr_master
module tb_apb_rr_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR-1:0]     req_write;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     done;
    logic [DW-1:0]     rdata_o;
    logic              err_o;
    logic              sel;
    logic              enable;
    logic              write;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     wdata;
    logic [DW-1:0]     rdata = '0;
    logic              ready = 1'b0;
    logic              err   = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    apb_rr_master #(
        .addrWidth (AW),
        .dataWidth (DW),
        .NUM_REQ   (NR),
        .TIMEOUT   (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .done      (done),
        .rdata_o   (rdata_o),
        .err_o     (err_o),
        .sel       (sel),
        .enable    (enable),
        .write     (write),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ready     (ready),
        .err       (err)
    );

    // Slave: 256-word memory preloaded with mem[a] = a, error at addr >= 0x100,
    // wait_n wait cycles per access, tie_low keeps ready at 0.
    logic [DW-1:0] smem [0:255];
    int wait_n  = 0;
    int wcnt    = 0;
    bit tie_low = 1'b0;

    always @(negedge clk) begin
        if (sel && enable && !tie_low) begin
            if (wcnt >= wait_n) begin
                ready = 1'b1;
                err   = (addr >= 32'h100);
                rdata = err ? '0 : smem[addr[7:0]];
                if (write && !err) smem[addr[7:0]] = wdata;
                wcnt  = 0;
            end else begin
                ready = 1'b0;
                wcnt++;
            end
        end else begin
            ready = 1'b0;
            err   = 1'b0;
            rdata = '0;
            wcnt  = 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NR-1:0] one_hot(input int i);
        logic [NR-1:0] m;
        m    = '0;
        m[0] = 1'b1;
        return m << i;
    endfunction

    task automatic set_payload(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        req_write = (req_write & ~one_hot(i)) | (wr ? one_hot(i) : '0);
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = wd;
    endtask

    task automatic do_reset();
        req = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One isolated transfer from requester idx; checks phase timing,
    // payload stability, latency, result and hold of the previous result.
    task automatic run_one(input string tag, input int idx, input bit wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] wd, input int wt,
                           input logic [DW-1:0] exp_rd, input bit exp_err,
                           input logic [DW-1:0] prev_rd, input int exp_lat);
        int c;
        bit got;
        bit stable;
        int en_cycles;
        wait_n = wt;
        @(posedge clk); #1;
        set_payload(idx, wr, a, wd);
        req = req | one_hot(idx);
        got = 1'b0; stable = 1'b1; en_cycles = 0; c = 0;
        while (!got && c < 60) begin
            @(posedge clk); #1;
            c++;
            if (c == 1) chk($sformatf("%s setup sel/en", tag), {sel, enable}, 64'h2);
            if (c == 2) chk($sformatf("%s hold rdata_o", tag), rdata_o, prev_rd);
            if (sel && (addr !== a || write !== wr)) stable = 1'b0;
            if (enable) en_cycles++;
            if (done != '0) got = 1'b1;
        end
        req = req & ~one_hot(idx);
        chk($sformatf("%s done seen", tag), got, 1);
        chk($sformatf("%s latency", tag), c, exp_lat);
        chk($sformatf("%s done one-hot", tag), done, one_hot(idx));
        chk($sformatf("%s rdata_o", tag), rdata_o, exp_rd);
        chk($sformatf("%s err_o", tag), err_o, exp_err);
        chk($sformatf("%s payload stable", tag), stable, 1);
        chk($sformatf("%s access cycles", tag), en_cycles, exp_lat - 2);
    endtask

    typedef struct {
        int            idx;
        bit            wr;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        int            wt;
        logic [DW-1:0] exp_rd;
        bit            exp_err;
    } vec_t;

    vec_t vt [8];

    // Reference state for the randomized phase.
    logic [DW-1:0] rmem [0:255];
    bit            pend [NR];
    bit            pw   [NR];
    logic [AW-1:0] pa   [NR];
    logic [DW-1:0] pd   [NR];

    initial begin
        logic [DW-1:0] prev;
        int c, nd, last_c, last, w, wt, j;
        bit got, any;
        logic [DW-1:0] exp_rd;
        bit exp_err;

        for (int i = 0; i < 256; i++) begin
            smem[i] = DW'(i);
            rmem[i] = DW'(i);
        end
        req = '0; req_write = '0; req_addr = '0; req_wdata = '0;

        // Reset state
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("reset sel", sel, 0);
        chk("reset enable", enable, 0);
        chk("reset done", done, 0);
        chk("reset rdata_o", rdata_o, 0);
        chk("reset err_o", err_o, 0);
        chk("reset write", write, 0);
        chk("reset addr", addr, 0);
        chk("reset wdata", wdata, 0);
        rst = 1'b0;

        // Single-transfer vectors
        vt[0] = '{0, 1'b1, 32'h04,  32'hA5,     0, 32'h0,    1'b0};
        vt[1] = '{1, 1'b0, 32'h10,  32'hDEAD,   0, 32'h10,   1'b0};
        vt[2] = '{2, 1'b0, 32'h04,  32'hBEEF,   0, 32'hA5,   1'b0};
        vt[3] = '{3, 1'b0, 32'h03,  32'h1,      3, 32'h03,   1'b0};
        vt[4] = '{1, 1'b1, 32'h100, 32'h77,     1, 32'h0,    1'b1};
        vt[5] = '{0, 1'b0, 32'h100, 32'h0,      0, 32'h0,    1'b1};
        vt[6] = '{2, 1'b1, 32'h20,  32'h1234,   2, 32'h0,    1'b0};
        vt[7] = '{3, 1'b0, 32'h20,  32'hFFFF,   1, 32'h1234, 1'b0};
        prev = '0;
        for (int k = 0; k < 8; k++) begin
            run_one($sformatf("vec%0d", k), vt[k].idx, vt[k].wr, vt[k].a, vt[k].wd, vt[k].wt,
                    vt[k].exp_rd, vt[k].exp_err, prev, 3 + vt[k].wt);
            prev = vt[k].exp_rd;
        end

        // Timeout: ready tied low -> 16 ACCESS cycles, done after them
        tie_low = 1'b1;
        run_one("timeout", 2, 1'b0, 32'h30, 32'h0, 0, 32'h0, 1'b1, prev, 2 + TO);
        tie_low = 1'b0;

        // Fairness with all requesters held
        do_reset();
        wait_n = 0;
        for (int i = 0; i < NR; i++) set_payload(i, 1'b0, AW'(32'h40 + i), '0);
        req = '1;
        nd = 0; c = 0; last_c = 0;
        while (nd < 5 && c < 60) begin
            @(posedge clk); #1;
            c++;
            if (done != '0) begin
                chk($sformatf("fair grant %0d", nd), done, one_hot(nd % NR));
                chk($sformatf("fair rdata %0d", nd), rdata_o, 32'h40 + (nd % NR));
                chk($sformatf("fair idle %0d", nd), sel, 0);
                chk($sformatf("fair spacing %0d", nd), c - last_c, 3);
                last_c = c;
                nd++;
            end
        end
        chk("fair count", nd, 5);
        req = '0;

        // Reset in ACCESS aborts; requester 0 wins afterwards
        @(posedge clk); #1;
        tie_low = 1'b1;
        set_payload(2, 1'b0, 32'h50, '0);
        req = one_hot(2);
        c = 0;
        while (!enable && c < 10) begin
            @(posedge clk); #1;
            c++;
        end
        chk("rst-access reached", enable, 1);
        set_payload(0, 1'b0, 32'h60, '0);
        req = req | one_hot(0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst-access sel", sel, 0);
        chk("rst-access enable", enable, 0);
        chk("rst-access done", done, 0);
        rst = 1'b0; tie_low = 1'b0; wait_n = 0;
        @(posedge clk); #1;
        chk("rst-access winner addr", {sel, addr}, {1'b1, 32'h60});
        for (int n = 0; n < 2; n++) begin
            got = 1'b0; c = 0;
            while (!got && c < 20) begin
                @(posedge clk); #1;
                c++;
                if (done != '0) got = 1'b1;
            end
            chk($sformatf("rst-access done %0d", n), done, one_hot(n == 0 ? 0 : 2));
            req = req & ~done;
        end
        req = '0;

        // Randomized traffic against a round-robin model
        do_reset();
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
        last = NR - 1;
        for (int t = 0; t < 40; t++) begin
            // New requests; the requester just served sits out this round.
            any = 1'b0;
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && (t == 0 || i != last) && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    pw[i] = 1'($urandom_range(0, 1));
                    pa[i] = AW'($urandom_range(32'h80, 32'h10F));
                    pd[i] = DW'($urandom);
                end
                if (pend[i]) any = 1'b1;
            end
            if (!any) begin
                j = (last + 1 + int'($urandom_range(0, NR - 2))) % NR;
                pend[j] = 1'b1;
                pw[j] = 1'b0;
                pa[j] = AW'($urandom_range(32'h80, 32'hFF));
                pd[j] = '0;
            end
            for (int i = 0; i < NR; i++) begin
                if (pend[i]) set_payload(i, pw[i], pa[i], pd[i]);
                req = pend[i] ? (req | one_hot(i)) : (req & ~one_hot(i));
            end
            w = -1;
            for (int k = 1; k <= NR; k++) begin
                j = (last + k) % NR;
                if (w < 0 && pend[j]) w = j;
            end
            wt = int'($urandom_range(0, 3));
            wait_n = wt;
            exp_err = (pa[w] >= 32'h100);
            exp_rd  = (pw[w] || exp_err) ? '0 : rmem[pa[w][7:0]];
            if (pw[w] && !exp_err) rmem[pa[w][7:0]] = pd[w];

            got = 1'b0; c = 0;
            while (!got && c < 40) begin
                @(posedge clk); #1;
                c++;
                if (done != '0) got = 1'b1;
            end
            chk($sformatf("rand%0d winner", t), done, one_hot(w));
            chk($sformatf("rand%0d latency", t), c, 3 + wt);
            chk($sformatf("rand%0d rdata_o", t), rdata_o, exp_rd);
            chk($sformatf("rand%0d err_o", t), err_o, exp_err);
            pend[w] = 1'b0;
            req = req & ~one_hot(w);
            last = w;
        end
        req = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
